// File: rtl/ip_chk_pkg.sv
// rtl/ip_chk_pkg.sv - shared IPv4 header checker types, constants and 1's-complement helpers
package ip_chk_pkg;

    localparam logic [3:0] IPV4_VERSION = 4'd4;
    localparam logic [3:0] IHL_MIN      = 4'd5;

    typedef enum logic [2:0] {
        ERR_OK    = 3'd0,
        ERR_SHORT = 3'd1,
        ERR_VER   = 3'd2,
        ERR_IHL   = 3'd3,
        ERR_CSUM  = 3'd4,
        ERR_LEN   = 3'd5
    } err_code_e;

    typedef enum logic {
        ST_HDR  = 1'b0,
        ST_BODY = 1'b1
    } chk_state_e;

    // Two end-around-carry folds reduce any 21-bit raw sum to 16 bits.
    function automatic logic [15:0] ones_fold(input logic [20:0] raw);
        logic [16:0] t;
        logic [15:0] r;
        t = {1'b0, raw[15:0]} + {12'b0, raw[20:16]};
        r = t[15:0] + {15'b0, t[16]};
        return r;
    endfunction

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b0, v[0]} + {2'b0, v[1]} + {2'b0, v[2]} + {2'b0, v[3]};
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// rtl/axis_reg_slice.sv - 2-entry stream register slice with registered ready
module axis_reg_slice (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] s_tdata,
    input  logic [3:0]  s_tstrb,
    input  logic        s_tlast,
    input  logic        s_tvalid,
    output logic        s_tready,
    output logic [31:0] m_tdata,
    output logic [3:0]  m_tstrb,
    output logic        m_tlast,
    output logic        m_tvalid,
    input  logic        m_tready
);

    logic [31:0] skid_tdata;
    logic [3:0]  skid_tstrb;
    logic        skid_tlast;
    logic        skid_valid;
    logic        skid_valid_nxt;
    logic        accept;
    logic        out_free;

    assign accept   = s_tvalid && s_tready;
    assign out_free = !m_tvalid || m_tready;

    // Ready is a register of "skid will be empty", so m_tready never reaches s_tready combinationally.
    always_comb begin
        skid_valid_nxt = skid_valid;
        if (out_free)
            skid_valid_nxt = 1'b0;
        else if (accept)
            skid_valid_nxt = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_tdata    <= '0;
            m_tstrb    <= '0;
            m_tlast    <= 1'b0;
            m_tvalid   <= 1'b0;
            skid_tdata <= '0;
            skid_tstrb <= '0;
            skid_tlast <= 1'b0;
            skid_valid <= 1'b0;
            s_tready   <= 1'b0;
        end else begin
            s_tready   <= !skid_valid_nxt;
            skid_valid <= skid_valid_nxt;
            if (out_free) begin
                if (skid_valid) begin
                    m_tdata  <= skid_tdata;
                    m_tstrb  <= skid_tstrb;
                    m_tlast  <= skid_tlast;
                    m_tvalid <= 1'b1;
                end else begin
                    m_tvalid <= accept;
                    if (accept) begin
                        m_tdata <= s_tdata;
                        m_tstrb <= s_tstrb;
                        m_tlast <= s_tlast;
                    end
                end
            end else if (accept) begin
                skid_tdata <= s_tdata;
                skid_tstrb <= s_tstrb;
                skid_tlast <= s_tlast;
            end
        end
    end

endmodule

// File: rtl/axis_ipv4_hdr_chk.sv
// rtl/axis_ipv4_hdr_chk.sv - in-line IPv4 header/length checker with pass-through egress
module axis_ipv4_hdr_chk
    import ip_chk_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             aclk_0,
    input  logic             aresetn_0,
    input  logic [31:0]      S_AXIS_0_tdata,
    input  logic [3:0]       S_AXIS_0_tstrb,
    input  logic             S_AXIS_0_tlast,
    input  logic             S_AXIS_0_tvalid,
    output logic             S_AXIS_0_tready,
    output logic [31:0]      M_AXIS_0_tdata,
    output logic [3:0]       M_AXIS_0_tstrb,
    output logic             M_AXIS_0_tlast,
    output logic             M_AXIS_0_tvalid,
    input  logic             M_AXIS_0_tready,
    output logic             pkt_done,
    output logic             pkt_ok,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    axis_reg_slice u_slice (
        .clk      (aclk_0),
        .resetn   (aresetn_0),
        .s_tdata  (S_AXIS_0_tdata),
        .s_tstrb  (S_AXIS_0_tstrb),
        .s_tlast  (S_AXIS_0_tlast),
        .s_tvalid (S_AXIS_0_tvalid),
        .s_tready (S_AXIS_0_tready),
        .m_tdata  (M_AXIS_0_tdata),
        .m_tstrb  (M_AXIS_0_tstrb),
        .m_tlast  (M_AXIS_0_tlast),
        .m_tvalid (M_AXIS_0_tvalid),
        .m_tready (M_AXIS_0_tready)
    );

    chk_state_e  state_q, state_d;
    logic [3:0]  idx_q;
    logic [3:0]  ver_q, ihl_q;
    logic [15:0] len_q;
    logic [20:0] sum_q;
    logic [15:0] bc_q;
    logic        ver_bad_q, ihl_bad_q, csum_bad_q;

    logic        acc, first, hdr_done;
    logic [3:0]  cur_ver, cur_ihl, hdr_last_idx;
    logic [15:0] cur_len;
    logic [20:0] sum_in;
    logic [16:0] bc_sum;
    logic [15:0] bc_new;
    logic        ver_bad_now, ihl_bad_now, csum_bad_now;
    err_code_e   err_sel;

    assign acc     = S_AXIS_0_tvalid && S_AXIS_0_tready;
    assign first   = (state_q == ST_HDR) && (idx_q == 4'd0);
    assign cur_ver = first ? S_AXIS_0_tdata[31:28] : ver_q;
    assign cur_ihl = first ? S_AXIS_0_tdata[27:24] : ihl_q;
    assign cur_len = first ? S_AXIS_0_tdata[15:0]  : len_q;

    // A too-small IHL still consumes a minimum-size header before the body starts.
    assign hdr_last_idx = (cur_ihl < IHL_MIN) ? (IHL_MIN - 4'd1) : (cur_ihl - 4'd1);
    assign hdr_done     = (state_q == ST_HDR) && (idx_q == hdr_last_idx);

    assign sum_in = (first ? 21'd0 : sum_q) + {5'b0, S_AXIS_0_tdata[31:16]}
                  + {5'b0, S_AXIS_0_tdata[15:0]};
    assign bc_sum = {1'b0, (first ? 16'd0 : bc_q)} + {14'b0, popcount4(S_AXIS_0_tstrb)};
    assign bc_new = bc_sum[16] ? 16'hFFFF : bc_sum[15:0];

    assign ver_bad_now  = (cur_ver != IPV4_VERSION);
    assign ihl_bad_now  = (cur_ihl < IHL_MIN);
    assign csum_bad_now = !ihl_bad_now && (ones_fold(sum_in) != 16'hFFFF);

    always_comb begin
        err_sel = ERR_OK;
        if (state_q == ST_HDR && !hdr_done)
            err_sel = ERR_SHORT;
        else if (state_q == ST_HDR ? ver_bad_now : ver_bad_q)
            err_sel = ERR_VER;
        else if (state_q == ST_HDR ? ihl_bad_now : ihl_bad_q)
            err_sel = ERR_IHL;
        else if (state_q == ST_HDR ? csum_bad_now : csum_bad_q)
            err_sel = ERR_CSUM;
        else if (bc_new != cur_len)
            err_sel = ERR_LEN;
    end

    always_comb begin
        state_d = state_q;
        if (acc) begin
            if (S_AXIS_0_tlast)
                state_d = ST_HDR;
            else if (hdr_done)
                state_d = ST_BODY;
        end
    end

    always_ff @(posedge aclk_0 or negedge aresetn_0) begin
        if (!aresetn_0)
            state_q <= ST_HDR;
        else
            state_q <= state_d;
    end

    always_ff @(posedge aclk_0 or negedge aresetn_0) begin
        if (!aresetn_0) begin
            idx_q      <= '0;
            ver_q      <= '0;
            ihl_q      <= '0;
            len_q      <= '0;
            sum_q      <= '0;
            bc_q       <= '0;
            ver_bad_q  <= 1'b0;
            ihl_bad_q  <= 1'b0;
            csum_bad_q <= 1'b0;
        end else if (acc) begin
            bc_q <= bc_new;
            if (first) begin
                ver_q <= S_AXIS_0_tdata[31:28];
                ihl_q <= S_AXIS_0_tdata[27:24];
                len_q <= S_AXIS_0_tdata[15:0];
            end
            if (state_q == ST_HDR) begin
                sum_q <= sum_in;
                idx_q <= (S_AXIS_0_tlast || hdr_done) ? 4'd0 : idx_q + 4'd1;
                if (hdr_done) begin
                    ver_bad_q  <= ver_bad_now;
                    ihl_bad_q  <= ihl_bad_now;
                    csum_bad_q <= csum_bad_now;
                end
            end
        end
    end

    always_ff @(posedge aclk_0 or negedge aresetn_0) begin
        if (!aresetn_0) begin
            pkt_done <= 1'b0;
            pkt_ok   <= 1'b0;
            err_code <= '0;
            pkt_cnt  <= '0;
            err_cnt  <= '0;
        end else begin
            pkt_done <= acc && S_AXIS_0_tlast;
            pkt_ok   <= acc && S_AXIS_0_tlast && (err_sel == ERR_OK);
            err_code <= (acc && S_AXIS_0_tlast) ? err_sel : ERR_OK;
            if (acc && S_AXIS_0_tlast) begin
                if (pkt_cnt != {CNT_W{1'b1}})
                    pkt_cnt <= pkt_cnt + 1'b1;
                if (err_sel != ERR_OK && err_cnt != {CNT_W{1'b1}})
                    err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_ipv4_hdr_chk.sv
// tb/tb_axis_ipv4_hdr_chk.sv - self-checking bench for axis_ipv4_hdr_chk
module tb_axis_ipv4_hdr_chk;

    logic        aclk_0 = 1'b0;
    logic        aresetn_0 = 1'b0;
    logic [31:0] S_AXIS_0_tdata = '0;
    logic [3:0]  S_AXIS_0_tstrb = '0;
    logic        S_AXIS_0_tlast = 1'b0;
    logic        S_AXIS_0_tvalid = 1'b0;
    logic        S_AXIS_0_tready;
    logic [31:0] M_AXIS_0_tdata;
    logic [3:0]  M_AXIS_0_tstrb;
    logic        M_AXIS_0_tlast;
    logic        M_AXIS_0_tvalid;
    logic        M_AXIS_0_tready = 1'b1;
    logic        pkt_done, pkt_ok;
    logic [2:0]  err_code;
    logic [15:0] pkt_cnt, err_cnt;

    axis_ipv4_hdr_chk #(.CNT_W(16)) dut (
        .aclk_0          (aclk_0),
        .aresetn_0       (aresetn_0),
        .S_AXIS_0_tdata  (S_AXIS_0_tdata),
        .S_AXIS_0_tstrb  (S_AXIS_0_tstrb),
        .S_AXIS_0_tlast  (S_AXIS_0_tlast),
        .S_AXIS_0_tvalid (S_AXIS_0_tvalid),
        .S_AXIS_0_tready (S_AXIS_0_tready),
        .M_AXIS_0_tdata  (M_AXIS_0_tdata),
        .M_AXIS_0_tstrb  (M_AXIS_0_tstrb),
        .M_AXIS_0_tlast  (M_AXIS_0_tlast),
        .M_AXIS_0_tvalid (M_AXIS_0_tvalid),
        .M_AXIS_0_tready (M_AXIS_0_tready),
        .pkt_done        (pkt_done),
        .pkt_ok          (pkt_ok),
        .err_code        (err_code),
        .pkt_cnt         (pkt_cnt),
        .err_cnt         (err_cnt)
    );

    always #5 aclk_0 = ~aclk_0;

    int vecs = 0;
    int miscompares = 0;
    int model_pkts = 0;
    int model_errs = 0;
    logic rnd_ready = 1'b0;
    logic rnd_gap = 1'b0;
    logic pend_done = 1'b0;

    logic [31:0] cur_pkt[$];
    logic [36:0] egq[$];
    logic [2:0]  stq[$];

    typedef struct {
        logic [31:0] word0;
        logic [31:0] word2;
        logic [3:0]  last_strb;
        int          nbeats;
        logic [2:0]  exp_code;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic build_base(input logic [31:0] w0, input logic [31:0] w2, input int nbeats);
        cur_pkt.delete();
        cur_pkt.push_back(w0);
        cur_pkt.push_back(32'h00004000);
        cur_pkt.push_back(w2);
        cur_pkt.push_back(32'hC0A80001);
        cur_pkt.push_back(32'hC0A800C7);
        for (int i = 0; i < 24; i++)
            cur_pkt.push_back(32'h10203040 + i);
        while (cur_pkt.size() > nbeats)
            void'(cur_pkt.pop_back());
    endtask

    // Reference: decide the verdict from the packet as a whole.
    function automatic logic [2:0] model_code(input logic [3:0] lstrb);
        int n, ver, ihl, hlen, len, bytes, sum;
        n     = cur_pkt.size();
        ver   = int'(cur_pkt[0][31:28]);
        ihl   = int'(cur_pkt[0][27:24]);
        len   = int'(cur_pkt[0][15:0]);
        hlen  = (ihl < 5) ? 5 : ihl;
        bytes = 4 * (n - 1) + int'(lstrb[0]) + int'(lstrb[1]) + int'(lstrb[2]) + int'(lstrb[3]);
        if (n < hlen) return 3'd1;
        if (ver != 4) return 3'd2;
        if (ihl < 5) return 3'd3;
        sum = 0;
        for (int i = 0; i < hlen; i++)
            sum += int'(cur_pkt[i][31:16]) + int'(cur_pkt[i][15:0]);
        while (sum > 32'hFFFF)
            sum = (sum & 32'hFFFF) + (sum >> 16);
        if (sum != 32'hFFFF) return 3'd4;
        if (bytes != len) return 3'd5;
        return 3'd0;
    endfunction

    task automatic send_cur(input logic [3:0] lstrb, input int stop_at, input logic [2:0] exp);
        int  cnt;
        logic ok;
        for (int i = 0; i < cur_pkt.size(); i++) begin
            if (i == stop_at) return;
            if (rnd_gap && ($urandom_range(0, 3) == 0)) begin
                S_AXIS_0_tvalid = 1'b0;
                @(posedge aclk_0); #1;
            end
            S_AXIS_0_tdata  = cur_pkt[i];
            S_AXIS_0_tlast  = (i == cur_pkt.size() - 1);
            S_AXIS_0_tstrb  = S_AXIS_0_tlast ? lstrb : 4'hF;
            S_AXIS_0_tvalid = 1'b1;
            cnt = 0;
            do begin
                @(negedge aclk_0);
                ok = S_AXIS_0_tready;
                @(posedge aclk_0); #1;
                cnt++;
            end while (!ok && cnt < 1000);
            if (!ok) begin
                vecs++;
                miscompares++;
                $display("FAIL ingress_timeout: beat %0d not accepted in %0d cycles", i, cnt);
                S_AXIS_0_tvalid = 1'b0;
                return;
            end
        end
        S_AXIS_0_tvalid = 1'b0;
        S_AXIS_0_tlast  = 1'b0;
        stq.push_back(exp);
    endtask

    always @(posedge aclk_0) begin
        #1;
        M_AXIS_0_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge aclk_0) begin
        logic [2:0]  e;
        logic [36:0] b;
        if (!aresetn_0) begin
            egq.delete();
            stq.delete();
            pend_done = 1'b0;
            model_pkts = 0;
            model_errs = 0;
        end else begin
            if (pkt_done || pend_done) begin
                chk("pkt_done_timing", {63'b0, pkt_done}, {63'b0, pend_done});
                if (pkt_done && pend_done) begin
                    if (stq.size() == 0) begin
                        chk("status_queue_empty", 64'd1, 64'd0);
                    end else begin
                        e = stq.pop_front();
                        chk("err_code", {61'b0, err_code}, {61'b0, e});
                        chk("pkt_ok", {63'b0, pkt_ok}, {63'b0, (e == 3'd0)});
                        model_pkts++;
                        if (e != 3'd0) model_errs++;
                    end
                end
            end
            pend_done = S_AXIS_0_tvalid && S_AXIS_0_tready && S_AXIS_0_tlast;
            if (M_AXIS_0_tvalid && M_AXIS_0_tready) begin
                if (egq.size() == 0) begin
                    chk("egress_extra_beat", 64'd1, 64'd0);
                end else begin
                    b = egq.pop_front();
                    chk("egress_beat", {27'b0, M_AXIS_0_tdata, M_AXIS_0_tstrb, M_AXIS_0_tlast}, {27'b0, b});
                end
            end
            if (S_AXIS_0_tvalid && S_AXIS_0_tready)
                egq.push_back({S_AXIS_0_tdata, S_AXIS_0_tstrb, S_AXIS_0_tlast});
        end
    end

    task automatic chk_reset_outputs(input string name);
        chk(name, {M_AXIS_0_tdata, M_AXIS_0_tstrb, M_AXIS_0_tlast, M_AXIS_0_tvalid,
                   S_AXIS_0_tready, pkt_done, pkt_ok, err_code}, 64'd0);
        chk({name, "_cnt"}, {32'b0, pkt_cnt, err_cnt}, 64'd0);
    endtask

    task automatic gen_random();
        int ihl, hlen, npay, lb, bytes, sum, n;
        logic [3:0] lstrb;
        ihl  = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(5, 7);
        hlen = (ihl < 5) ? 5 : ihl;
        npay = $urandom_range(0, 6);
        lb   = $urandom_range(1, 4);
        lstrb = 4'hF << (4 - lb);
        bytes = 4 * (hlen + npay - 1) + lb;
        if ($urandom_range(0, 9) == 0) bytes++;
        cur_pkt.delete();
        cur_pkt.push_back({($urandom_range(0, 9) == 0) ? 4'd6 : 4'd4, 4'(ihl), 8'h00, 16'(bytes)});
        for (int i = 1; i < hlen + npay; i++)
            cur_pkt.push_back($urandom);
        cur_pkt[2][15:0] = 16'h0000;
        sum = 0;
        for (int i = 0; i < hlen; i++)
            sum += int'(cur_pkt[i][31:16]) + int'(cur_pkt[i][15:0]);
        while (sum > 32'hFFFF)
            sum = (sum & 32'hFFFF) + (sum >> 16);
        cur_pkt[2][15:0] = ~16'(sum);
        if ($urandom_range(0, 9) == 0) cur_pkt[1][3] = ~cur_pkt[1][3];
        if ($urandom_range(0, 9) == 0) begin
            n = $urandom_range(1, hlen - 1);
            while (cur_pkt.size() > n) void'(cur_pkt.pop_back());
        end
        send_cur(lstrb, -1, model_code(lstrb));
    endtask

    vec_t vt[6];

    initial begin
        int cnt;
        vt[0] = '{32'h45000073, 32'h4011B861, 4'b1110, 29, 3'd0};
        vt[1] = '{32'h45000073, 32'h4011B862, 4'b1110, 29, 3'd4};
        vt[2] = '{32'h45000073, 32'h4011B861, 4'b1100, 29, 3'd5};
        vt[3] = '{32'h45000073, 32'h4011B861, 4'b1111, 3,  3'd1};
        vt[4] = '{32'h45000073, 32'h4011B861, 4'b1110, 29, 3'd0};
        vt[5] = '{32'h65000073, 32'h4011B862, 4'b1110, 29, 3'd2};

        #2;
        chk_reset_outputs("reset_state");
        repeat (2) @(posedge aclk_0);
        @(negedge aclk_0);
        aresetn_0 = 1'b1;
        #1;
        chk("tready_before_first_clk", {63'b0, S_AXIS_0_tready}, 64'd0);
        @(posedge aclk_0); #1;
        chk("tready_after_first_clk", {63'b0, S_AXIS_0_tready}, 64'd1);

        for (int i = 0; i < 6; i++) begin
            build_base(vt[i].word0, vt[i].word2, vt[i].nbeats);
            send_cur(vt[i].last_strb, -1, vt[i].exp_code);
        end
        repeat (4) @(posedge aclk_0);
        #1;
        chk("table_pkt_cnt", {48'b0, pkt_cnt}, 64'd6);
        chk("table_err_cnt", {48'b0, err_cnt}, 64'd4);

        build_base(32'h45000073, 32'h4011B861, 29);
        send_cur(4'b1110, 10, 3'd0);
        #2;
        aresetn_0 = 1'b0;
        S_AXIS_0_tvalid = 1'b0;
        #1;
        chk_reset_outputs("midpkt_reset");
        repeat (3) @(posedge aclk_0);
        chk("midpkt_no_done", {63'b0, pkt_done}, 64'd0);
        @(negedge aclk_0);
        aresetn_0 = 1'b1;
        @(posedge aclk_0); #1;
        chk("tready_after_midpkt_reset", {63'b0, S_AXIS_0_tready}, 64'd1);
        build_base(32'h45000073, 32'h4011B861, 29);
        send_cur(4'b1110, -1, 3'd0);
        repeat (4) @(posedge aclk_0);
        #1;
        chk("post_reset_pkt_cnt", {32'b0, 16'(pkt_cnt), 16'(err_cnt)}, {32'b0, 16'd1, 16'd0});

        rnd_ready = 1'b1;
        rnd_gap   = 1'b1;
        for (int p = 0; p < 100; p++)
            gen_random();
        rnd_gap = 1'b0;

        cnt = 0;
        while ((egq.size() != 0 || stq.size() != 0) && cnt < 500) begin
            @(posedge aclk_0);
            cnt++;
        end
        chk("drain_egress_left", {32'b0, 32'(egq.size())}, 64'd0);
        chk("drain_status_left", {32'b0, 32'(stq.size())}, 64'd0);
        repeat (3) @(posedge aclk_0);
        #1;
        chk("final_pkt_cnt", {48'b0, pkt_cnt}, {48'b0, 16'(model_pkts)});
        chk("final_err_cnt", {48'b0, err_cnt}, {48'b0, 16'(model_errs)});

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule

// File: doc/axis_ipv4_hdr_chk.md
AXIS_IPV4_HDR_CHK -- requirements
Module: axis_ipv4_hdr_chk

Interface
REQ-001 Parameter CNT_W, default 16: width of the packet and error counters.
REQ-002 Port aclk_0, input, 1: sole clock; all logic is on its rising edge.
REQ-003 Port aresetn_0, input, 1: asynchronous, active-low reset.
REQ-004 Port S_AXIS_0_tdata, input, 32: ingress data; [31:24] is the first byte on the wire (big-endian).
REQ-005 Port S_AXIS_0_tstrb, input, 4: byte valid flags; bit 3 qualifies [31:24].
REQ-006 Port S_AXIS_0_tlast, input, 1: final beat of an IPv4 packet.
REQ-007 Port S_AXIS_0_tvalid, input, 1: ingress beat valid.
REQ-008 Port S_AXIS_0_tready, output, 1: ingress beat accepted when tvalid and tready are both high.
REQ-009 Ports M_AXIS_0_tdata/tstrb/tlast/tvalid, outputs, 32/4/1/1: egress copy of the ingress stream.
REQ-010 Port M_AXIS_0_tready, input, 1: egress backpressure.
REQ-011 Port pkt_done, output, 1: one-cycle pulse at the end of each packet.
REQ-012 Port pkt_ok, output, 1: valid with pkt_done; high when err_code is OK.
REQ-013 Port err_code, output, 3: valid with pkt_done; 0 OK, 1 SHORT, 2 VER, 3 IHL, 4 CSUM, 5 LEN.
REQ-014 Ports pkt_cnt/err_cnt, outputs, CNT_W: saturating counts of all packets and of errored packets.

Function
REQ-015 Egress passes through a 2-entry register slice: 1-cycle latency, full throughput, data/strobe/last unmodified and never dropped.
REQ-016 S_AXIS_0_tready is high whenever the slice holds fewer than 2 beats; no combinational path from M_AXIS_0_tready to S_AXIS_0_tready.
REQ-017 FSM states: HDR and BODY; only accepted ingress beats advance it.
REQ-018 In HDR, a 4-bit word index counts from 0; word 0 latches version [31:28], IHL [27:24] and total length [15:0].
REQ-019 Each HDR word adds [31:16] and [15:0] into a 21-bit raw sum; sum is cleared at packet start.
REQ-020 When the index reaches IHL-1, the FSM goes to BODY: the sum (including that word) is folded twice (end-around carry to 16 bits); CSUM is raised unless the result is 0xFFFF.
REQ-021 If IHL < 5, the header is treated as 5 words for the transition; IHL error applies and CSUM is not evaluated.
REQ-022 A byte counter (16 bits, saturating) adds the popcount of tstrb on every accepted beat, header beats included.
REQ-023 On accepted tlast, in either state: LEN is raised if byte count (including this beat) != total length; the FSM returns to HDR, index 0.
REQ-024 tlast while still in HDR before the header completes is SHORT; VER, IHL and CSUM are not evaluated for that packet.
REQ-025 tlast on the header's final word completes the header first; all checks apply.
REQ-026 pkt_done pulses exactly one cycle after the accepted tlast beat; err_code reports the highest-priority error: SHORT > VER > IHL > CSUM > LEN.
REQ-027 pkt_cnt increments with every pkt_done and err_cnt with every pkt_done where pkt_ok is 0; both hold at all-ones.
REQ-028 Back-to-back packets, where tlast is followed by the next first word in the following cycle, are checked independently at full rate.

Reset
REQ-029 Reset forces: all M_AXIS_0 outputs 0, S_AXIS_0_tready 0, pkt_done/pkt_ok/err_code 0, counters 0, FSM HDR, index/sums 0.
REQ-030 S_AXIS_0_tready rises on the first clock after deassertion.
REQ-031 Reset mid-packet discards slice contents and partial status; no pkt_done is issued for that packet.
REQ-032 The first beat accepted after reset is a packet's word 0.

Structure
REQ-033 Shared package ip_chk_pkg holds the err_code enum, the IPV4_VERSION=4 and IHL_MIN=5 constants, and the 1's-complement fold function.
REQ-034 The egress register slice is a sub-module named axis_reg_slice (32-bit data, 4-bit strobe, last).

Verification
REQ-035 Header 45000073 00004000 4011B861 C0A80001 C0A800C7 plus 24 words of payload; last beat tstrb=1110 (115 bytes, 29 beats) -> pkt_done with err_code 0, pkt_cnt=1.
REQ-036 Same packet with word 2 = 4011B862 -> err_code 4, err_cnt=1.
REQ-037 Same packet with last beat tstrb=1100 (114 bytes) -> err_code 5.
REQ-038 tlast on word 2 of the header -> err_code 1; next packet, sent back-to-back, is checked normally.
REQ-039 Word 0 = 65000073 -> err_code 2, even though CSUM also fails.
REQ-040 Random M_AXIS_0_tready at 50% over 100 packets -> egress beats match ingress exactly; no loss or duplication.
REQ-041 aresetn_0 asserted at beat 10 of a packet -> outputs take reset values asynchronously; no pkt_done; next packet reports err_code 0.
